// File: rtl/timer_ctrl_cd_if.sv
// Front-panel / display bundle for the two-digit BCD timer controller.
// master = keys and prescaler side, slave = timer_ctrl_cd.
interface timer_ctrl_cd_if;
    logic       start;
    logic       stop;
    logic       load;
    logic [7:0] load_val;
    logic       up;
    logic       tick;
    logic [3:0] S_tens;
    logic [3:0] S_units;
    logic [1:0] state;
    logic       running;
    logic       done;
    logic       load_err;

    modport master (
        output start, stop, load, load_val, up, tick,
        input  S_tens, S_units, state, running, done, load_err
    );

    modport slave (
        input  start, stop, load, load_val, up, tick,
        output S_tens, S_units, state, running, done, load_err
    );
endinterface

// File: rtl/timer_ctrl_cd.sv
// Sequencer for a two-digit BCD up/down count (tens:units) with start/stop/load keys,
// terminal-count detection and load validation. All outputs are registered.
module timer_ctrl_cd #(
    parameter logic [7:0] LIMIT = 8'h59
) (
    input logic           clock,
    input logic           reset,
    timer_ctrl_cd_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t     state_q;
    logic [3:0] tens_q;
    logic [3:0] units_q;
    logic       running_q;
    logic       done_q;
    logic       load_err_q;

    logic [7:0] digits;
    logic [7:0] step_val;
    logic       load_ok;
    logic       at_term;
    logic       step_term;

    always_comb begin
        digits  = {tens_q, units_q};
        load_ok = (bus.load_val[7:4] <= 4'd9) && (bus.load_val[3:0] <= 4'd9)
                  && (bus.load_val <= LIMIT);
        step_val = digits;
        if (bus.up) begin
            if (units_q == 4'd9) step_val = {tens_q + 4'd1, 4'd0};
            else                 step_val = {tens_q, units_q + 4'd1};
        end else begin
            if (units_q == 4'd0) step_val = {tens_q - 4'd1, 4'd9};
            else                 step_val = {tens_q, units_q - 4'd1};
        end
        at_term   = bus.up ? (digits == LIMIT)   : (digits == 8'h00);
        step_term = bus.up ? (step_val == LIMIT) : (step_val == 8'h00);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tens_q     <= '0;
            units_q    <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            if (bus.stop) begin
                state_q   <= (state_q == RUN) ? PAUSE : IDLE;
                running_q <= 1'b0;
            end else if (bus.load) begin
                // A held invalid load alternates the flag so it never stays high two cycles.
                if (load_ok) {tens_q, units_q} <= bus.load_val;
                else         load_err_q <= ~load_err_q;
                state_q   <= IDLE;
                running_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            if (at_term) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q   <= RUN;
                                running_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        // Already at terminal for the current direction (up flipped): no wrap.
                        if (bus.tick) begin
                            if (at_term) begin
                                state_q   <= DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                {tens_q, units_q} <= step_val;
                                if (step_term) begin
                                    state_q   <= DONE;
                                    running_q <= 1'b0;
                                    done_q    <= 1'b1;
                                end
                            end
                        end
                    end
                    PAUSE: begin
                        if (bus.start) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    DONE: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.S_tens   = tens_q;
    assign bus.S_units  = units_q;
    assign bus.state    = state_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;

endmodule
